// File: rtl/haze_synthesis.sv
// rtl/haze_synthesis.sv - forward haze model I = (J*t + A*(256-t) + 128) >> 8, 3-stage valid/ready pipeline
//
// Ports:
//   clock, reset_n            single posedge clock, asynchronous active-low reset
//   in_valid/in_ready         input handshake; in_ready is the pipeline advance enable
//   in_sof                    first pixel of a frame; qualifies A_r/A_g/A_b
//   J_r/J_g/J_b, t            clean pixel and transmission (1/256 units)
//   A_r/A_g/A_b               atmospheric light, sampled only on an accepted sof beat
//   out_valid/out_ready       output handshake
//   out_sof/out_eof           frame markers travelling with the pixel
//   I_r/I_g/I_b               hazy pixel
//   frame_err                 sticky: sof arrived while a frame was still in progress
module haze_synthesis #(
    parameter int FRAME_PIXELS = 307200,
    parameter int CNT_W        = 19
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_sof,
    input  logic [7:0] J_r,
    input  logic [7:0] J_g,
    input  logic [7:0] J_b,
    input  logic [7:0] t,
    input  logic [7:0] A_r,
    input  logic [7:0] A_g,
    input  logic [7:0] A_b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_sof,
    output logic       out_eof,
    output logic [7:0] I_r,
    output logic [7:0] I_g,
    output logic [7:0] I_b,
    output logic       frame_err
);

    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIXELS - 1);

    logic                  adv;
    logic                  accept;
    logic [2:0][7:0]       j_in;
    logic [2:0][7:0]       a_in;
    logic [2:0][7:0]       a_lat;
    logic [2:0][7:0]       a_eff;

    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      beat_cnt;
    logic                  beat_eof;

    logic                  s1_valid, s1_sof, s1_eof;
    logic [2:0][7:0]       s1_j;
    logic [2:0][7:0]       s1_a;
    logic [7:0]            s1_t;

    logic                  s2_valid, s2_sof, s2_eof;
    logic [2:0][15:0]      s2_p;
    logic [2:0][16:0]      s2_q;

    logic [2:0][16:0]      s_sum;
    logic [2:0][8:0]       s_hi;
    logic [2:0][7:0]       i_next;
    logic [2:0][7:0]       i_out;

    // A single enable moves every stage together; a full output stage that
    // is not being taken freezes the whole pipe so nothing is lost.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign accept   = in_valid && adv;

    assign j_in = {J_r, J_g, J_b};
    assign a_in = {A_r, A_g, A_b};

    assign I_r = i_out[2];
    assign I_g = i_out[1];
    assign I_b = i_out[0];

    // A sof beat uses its own A inputs and restarts the frame count at 0.
    always_comb begin
        a_eff    = in_sof ? a_in : a_lat;
        beat_cnt = in_sof ? '0 : cnt;
        beat_eof = (beat_cnt == LAST_PIX);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            a_lat     <= {3{8'hFF}};
            frame_err <= 1'b0;
        end else if (accept) begin
            cnt <= beat_eof ? '0 : beat_cnt + 1'b1;
            if (in_sof) begin
                a_lat <= a_in;
                if (cnt != '0) begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

    // Final sum; the upper clamp cannot trigger for 8-bit operands but guards
    // against a 17-bit sum wrapping into a small value.
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            s_sum[c]  = 17'(s2_p[c]) + s2_q[c] + 17'd128;
            s_hi[c]   = 9'(s_sum[c] >> 8);
            i_next[c] = s_hi[c][8] ? 8'hFF : s_hi[c][7:0];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s1_sof    <= 1'b0;
            s1_eof    <= 1'b0;
            s1_j      <= '0;
            s1_a      <= '0;
            s1_t      <= '0;
            s2_valid  <= 1'b0;
            s2_sof    <= 1'b0;
            s2_eof    <= 1'b0;
            s2_p      <= '0;
            s2_q      <= '0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            i_out     <= '0;
        end else if (adv) begin
            s1_valid <= accept;
            s1_sof   <= in_sof;
            s1_eof   <= beat_eof;
            s1_j     <= j_in;
            s1_a     <= a_eff;
            s1_t     <= t;

            s2_valid <= s1_valid;
            s2_sof   <= s1_sof;
            s2_eof   <= s1_eof;
            for (int c = 0; c < 3; c++) begin
                s2_p[c] <= 16'(s1_j[c]) * 16'(s1_t);
                s2_q[c] <= 17'(s1_a[c]) * (17'd256 - 17'(s1_t));
            end

            out_valid <= s2_valid;
            out_sof   <= s2_sof;
            out_eof   <= s2_eof;
            i_out     <= i_next;
        end
    end

endmodule

// File: tb/tb_haze_synthesis.sv
// tb/tb_haze_synthesis.sv - scoreboard bench for haze_synthesis
module tb_haze_synthesis;

    logic       clock;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic       in_sof;
    logic [7:0] J_r, J_g, J_b, t, A_r, A_g, A_b;
    logic       out_valid;
    logic       out_ready;
    logic       out_sof;
    logic       out_eof;
    logic [7:0] I_r, I_g, I_b;
    logic       frame_err;

    int n_checks = 0;
    int n_fail   = 0;

    // {I_r, I_g, I_b, sof, eof}
    logic [25:0] sb[$];

    haze_synthesis #(.FRAME_PIXELS(4), .CNT_W(19)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
        .J_r(J_r), .J_g(J_g), .J_b(J_b), .t(t),
        .A_r(A_r), .A_g(A_g), .A_b(A_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sof(out_sof), .out_eof(out_eof),
        .I_r(I_r), .I_g(I_g), .I_b(I_b),
        .frame_err(frame_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] haze(input int j, input int tt, input int a);
        int s;
        s = j * tt + a * (256 - tt) + 128;
        return (s > 65535) ? 8'd255 : 8'(s >> 8);
    endfunction

    // Monitor: pop on transfer, compare against the head while stalled.
    always @(negedge clock) begin
        if (reset_n && out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_beat", 32'd1, 32'd0);
            end else if (out_ready) begin
                check("beat", {6'd0, I_r, I_g, I_b, out_sof, out_eof}, {6'd0, sb.pop_front()});
            end else begin
                check("stall_hold", {6'd0, I_r, I_g, I_b, out_sof, out_eof}, {6'd0, sb[0]});
                check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            end
        end
    end

    task automatic send(input logic sof, input logic [7:0] ar, ag, ab,
                        input logic [7:0] jr, jg, jb, input logic [7:0] tt,
                        input logic [7:0] er, eg, eb, input logic eeof);
        int n;
        in_sof = sof; A_r = ar; A_g = ag; A_b = ab;
        J_r = jr; J_g = jg; J_b = jb; t = tt;
        in_valid = 1'b1;
        n = 0;
        forever begin
            @(posedge clock);
            if (in_ready) begin
                sb.push_back({er, eg, eb, sof, eeof});
                break;
            end
            n++;
            if (n > 200) begin
                check("accept_timeout", 32'd1, 32'd0);
                break;
            end
        end
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clock);
            n++;
        end
        check("drain", sb.size(), 32'd0);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
        J_r = 0; J_g = 0; J_b = 0; t = 0; A_r = 0; A_g = 0; A_b = 0;
        #22;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sof_eof",   {30'd0, out_sof, out_eof}, 32'd0);
        check("rst_I",         {8'd0, I_r, I_g, I_b}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready}, 32'd1);
        @(negedge clock);
        reset_n = 1'b1;

        // Frame 1: latency and basic arithmetic
        send(1, 100, 100, 100, 200, 200, 200, 128, 150, 150, 150, 0);
        check("lat_1", {31'd0, out_valid}, 32'd0);
        @(posedge clock); #1;
        check("lat_2", {31'd0, out_valid}, 32'd0);
        @(posedge clock); #1;
        check("lat_3", {31'd0, out_valid}, 32'd1);
        send(0, 0, 0, 0,  50,  50,  50,   0, 100, 100, 100, 0);
        send(0, 0, 0, 0,   0,   0,   0, 255,   0,   0,   0, 0);
        send(0, 0, 0, 0, 255, 255, 255, 255, 254, 254, 254, 1);
        drain();

        // Frame 2: t extremes
        send(1, 37, 90, 255, 11, 22, 33,   0, 37, 90, 255, 0);
        send(0,  0,  0,   0,  0,  0,  0, 255,  0,  0,   1, 0);
        send(0,  0,  0,   0, 255, 255, 255, 255, 254, 254, 255, 0);
        send(0,  0,  0,   0,  0,  0,  0,   0, 37, 90, 255, 1);
        drain();

        // Frame 3: latched A used on non-sof beats
        send(1, 250, 250, 250, 1, 2, 3,  0, 250, 250, 250, 0);
        send(0,   0,   0,   0, 10, 10, 10, 64, 190, 190, 190, 0);
        send(0,   0,   0,   0, 0, 0, 0,  0, 250, 250, 250, 0);
        send(0,   0,   0,   0, 0, 0, 0,  0, 250, 250, 250, 1);
        drain();
        check("no_err_yet", {31'd0, frame_err}, 32'd0);

        // Frames 4-5: 8-beat stream with a 5-cycle output stall
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(i == 0, 200, 150, 100, 8'(i * 30), 8'(255 - i * 30), 8'(i * 7), 8'(i * 36),
                         haze(i * 30, i * 36, 200), haze(255 - i * 30, i * 36, 150),
                         haze(i * 7, i * 36, 100), (i == 3) || (i == 7));
                end
            end
            begin
                repeat (4) @(posedge clock);
                #2 out_ready = 1'b0;
                repeat (5) @(posedge clock);
                #2 out_ready = 1'b1;
            end
        join
        drain();

        // Frame error: sof on the third beat of a frame
        send(1, 10, 20, 30, 0, 0, 0, 0, 10, 20, 30, 0);
        send(0,  0,  0,  0, 0, 0, 0, 0, 10, 20, 30, 0);
        check("frame_err_before", {31'd0, frame_err}, 32'd0);
        send(1, 40, 50, 60, 0, 0, 0, 0, 40, 50, 60, 0);
        check("frame_err_set", {31'd0, frame_err}, 32'd1);
        send(0,  0,  0,  0, 0, 0, 0, 0, 40, 50, 60, 0);
        drain();
        check("frame_err_sticky", {31'd0, frame_err}, 32'd1);

        // Reset with three beats in flight
        send(0, 0, 0, 0, 0, 0, 0, 0, 40, 50, 60, 0);
        send(0, 0, 0, 0, 0, 0, 0, 0, 40, 50, 60, 1);
        send(0, 0, 0, 0, 0, 0, 0, 0, 40, 50, 60, 0);
        check("inflight_valid", {31'd0, out_valid}, 32'd1);
        reset_n = 1'b0;
        sb.delete();
        #1;
        check("async_rst_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_err",   {31'd0, frame_err}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        send(0, 1, 2, 3, 9, 9, 9, 0, 255, 255, 255, 0);
        drain();
        check("post_rst_err", {31'd0, frame_err}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
